// File: rtl/wb_commit_checker.sv
// Writeback commit monitor: shadows the core's register writebacks, detects program end or timeout,
// then checks the shadow file against a loaded expected table. Define WBCHK_TRACE_EN for a commit trace ring buffer.
module wb_commit_checker #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NREGS       = 16,
    parameter int unsigned NCHECKS     = 8,
    parameter logic [31:0] END_PC      = 32'h0000_0040,
    parameter int unsigned END_HOLD    = 3,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        RegWriteW,
    input  logic [$clog2(NREGS)-1:0]    WA3W,
    input  logic [XLEN-1:0]             ResultW,
    input  logic [31:0]                 PCF,
    input  logic                        exp_we,
    input  logic [$clog2(NCHECKS)-1:0]  exp_idx,
    input  logic [$clog2(NREGS)-1:0]    exp_reg,
    input  logic [XLEN-1:0]             exp_val,
    input  logic                        exp_valid,
`ifdef WBCHK_TRACE_EN
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [$clog2(NREGS)-1:0]    trace_reg,
    output logic [XLEN-1:0]             trace_val,
`endif
    output logic                        done,
    output logic                        pass,
    output logic                        fail,
    output logic                        timeout,
    output logic [$clog2(NREGS)-1:0]    err_reg,
    output logic [XLEN-1:0]             err_got,
    output logic [XLEN-1:0]             err_exp,
    output logic [31:0]                 cycle_count,
    output logic [31:0]                 commit_count
);

    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NCHECKS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_PASS  = 3'd3;
    localparam logic [2:0] S_FAIL  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [XLEN-1:0]    shadow_q [NREGS];
    logic [NCHECKS-1:0] expValid_q;
    logic [AW-1:0]      expReg_q [NCHECKS];
    logic [XLEN-1:0]    expVal_q [NCHECKS];
    logic [31:0]        cycle_q, cycle_d, commit_q, commit_d, hold_q, hold_d;
    logic [CW-1:0]      checkIdx_q, checkIdx_d;
    logic               done_q, done_d, pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
    logic [AW-1:0]      errReg_q, errReg_d;
    logic [XLEN-1:0]    errGot_q, errGot_d, errExp_q, errExp_d;
    logic               endHit, slotMiss;
    logic [31:0]        cycleInc;

    // End is declared on the cycle the hold counter would reach END_HOLD.
    assign endHit   = (state_q == S_RUN) && (PCF == END_PC) && (hold_q == 32'(END_HOLD - 1));
    assign slotMiss = expValid_q[checkIdx_q] &&
                      (shadow_q[expReg_q[checkIdx_q]] != expVal_q[checkIdx_q]);
    assign cycleInc = (cycle_q == 32'hFFFF_FFFF) ? cycle_q : cycle_q + 32'd1;

    always_comb begin
        state_d    = state_q;
        cycle_d    = cycle_q;
        commit_d   = commit_q;
        hold_d     = hold_q;
        checkIdx_d = checkIdx_q;
        done_d     = done_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        timeout_d  = timeout_q;
        errReg_d   = errReg_q;
        errGot_d   = errGot_q;
        errExp_d   = errExp_q;
        if (start) begin
            state_d    = S_RUN;
            cycle_d    = '0;
            commit_d   = '0;
            hold_d     = '0;
            checkIdx_d = '0;
            done_d     = 1'b0;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
            timeout_d  = 1'b0;
            errReg_d   = '0;
            errGot_d   = '0;
            errExp_d   = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (RegWriteW && commit_q != 32'hFFFF_FFFF) commit_d = commit_q + 32'd1;
                    hold_d = (PCF == END_PC) ? hold_q + 32'd1 : 32'd0;
                    // End beats timeout; the timeout cycle itself is not counted.
                    if (endHit) begin
                        state_d    = S_CHECK;
                        checkIdx_d = '0;
                        cycle_d    = cycleInc;
                    end else if (cycle_q == 32'(TIMEOUT - 1)) begin
                        state_d   = S_FAIL;
                        fail_d    = 1'b1;
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        cycle_d = cycleInc;
                    end
                end
                S_CHECK: begin
                    if (slotMiss) begin
                        errReg_d = expReg_q[checkIdx_q];
                        errGot_d = shadow_q[expReg_q[checkIdx_q]];
                        errExp_d = expVal_q[checkIdx_q];
                        state_d  = S_FAIL;
                        fail_d   = 1'b1;
                        done_d   = 1'b1;
                    end else if (checkIdx_q == CW'(NCHECKS - 1)) begin
                        state_d = S_PASS;
                        pass_d  = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        checkIdx_d = checkIdx_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cycle_q    <= '0;
            commit_q   <= '0;
            hold_q     <= '0;
            checkIdx_q <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            timeout_q  <= 1'b0;
            errReg_q   <= '0;
            errGot_q   <= '0;
            errExp_q   <= '0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            commit_q   <= commit_d;
            hold_q     <= hold_d;
            checkIdx_q <= checkIdx_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            timeout_q  <= timeout_d;
            errReg_q   <= errReg_d;
            errGot_q   <= errGot_d;
            errExp_q   <= errExp_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREGS); i++) shadow_q[i] <= '0;
        end else if (start) begin
            for (int i = 0; i < int'(NREGS); i++) shadow_q[i] <= '0;
        end else if (state_q == S_RUN && RegWriteW) begin
            shadow_q[WA3W] <= ResultW;
        end
    end

    // The expected table survives start so a program can be rerun without reloading.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            expValid_q <= '0;
            for (int i = 0; i < int'(NCHECKS); i++) begin
                expReg_q[i] <= '0;
                expVal_q[i] <= '0;
            end
        end else if (exp_we && state_q == S_IDLE) begin
            expValid_q[exp_idx] <= exp_valid;
            expReg_q[exp_idx]   <= exp_reg;
            expVal_q[exp_idx]   <= exp_val;
        end
    end

`ifdef WBCHK_TRACE_EN
    localparam int TW = $clog2(TRACE_DEPTH);

    logic [AW-1:0]   trReg_q [TRACE_DEPTH];
    logic [XLEN-1:0] trVal_q [TRACE_DEPTH];
    logic [TW-1:0]   trPtr_q, trRd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trPtr_q <= '0;
            for (int i = 0; i < int'(TRACE_DEPTH); i++) begin
                trReg_q[i] <= '0;
                trVal_q[i] <= '0;
            end
        end else if (start) begin
            trPtr_q <= '0;
            for (int i = 0; i < int'(TRACE_DEPTH); i++) begin
                trReg_q[i] <= '0;
                trVal_q[i] <= '0;
            end
        end else if (state_q == S_RUN && RegWriteW) begin
            trReg_q[trPtr_q] <= WA3W;
            trVal_q[trPtr_q] <= ResultW;
            trPtr_q          <= trPtr_q + TW'(1);
        end
    end

    // trPtr_q points at the next free slot, so the newest entry sits one behind it.
    assign trRd      = trPtr_q - TW'(1) - trace_idx;
    assign trace_reg = trReg_q[trRd];
    assign trace_val = trVal_q[trRd];
`endif

    assign done         = done_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign timeout      = timeout_q;
    assign err_reg      = errReg_q;
    assign err_got      = errGot_q;
    assign err_exp      = errExp_q;
    assign cycle_count  = cycle_q;
    assign commit_count = commit_q;

endmodule

// File: tb/tb_wb_commit_checker.sv
// Directed bench for wb_commit_checker: pass, mismatch, timeout, end-vs-timeout, async reset,
// and (with WBCHK_TRACE_EN) the commit trace ring buffer.
module tb_wb_commit_checker;

    localparam logic [31:0] END_PC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        RegWriteW = 1'b0;
    logic [3:0]  WA3W = '0;
    logic [31:0] ResultW = '0;
    logic [31:0] PCF = '0;
    logic        exp_we = 1'b0;
    logic [2:0]  exp_idx = '0;
    logic [3:0]  exp_reg = '0;
    logic [31:0] exp_val = '0;
    logic        exp_valid = 1'b0;
    logic        done, pass, fail, timeout;
    logic [3:0]  err_reg;
    logic [31:0] err_got, err_exp, cycle_count, commit_count;
`ifdef WBCHK_TRACE_EN
    logic [1:0]  trace_idx = '0;
    logic [3:0]  trace_reg;
    logic [31:0] trace_val;
`endif

    int testCount = 0;
    int failCount = 0;
    int waited;

    always #5 clk = ~clk;

    wb_commit_checker #(
        .TIMEOUT     (16),
        .TRACE_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .RegWriteW    (RegWriteW),
        .WA3W         (WA3W),
        .ResultW      (ResultW),
        .PCF          (PCF),
        .exp_we       (exp_we),
        .exp_idx      (exp_idx),
        .exp_reg      (exp_reg),
        .exp_val      (exp_val),
        .exp_valid    (exp_valid),
`ifdef WBCHK_TRACE_EN
        .trace_idx    (trace_idx),
        .trace_reg    (trace_reg),
        .trace_val    (trace_val),
`endif
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .err_reg      (err_reg),
        .err_got      (err_got),
        .err_exp      (err_exp),
        .cycle_count  (cycle_count),
        .commit_count (commit_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        testCount++;
        if (got !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [31:0] val,
                                 input logic [31:0] pc);
        RegWriteW = we;
        WA3W      = wa;
        ResultW   = val;
        PCF       = pc;
        tick();
        RegWriteW = 1'b0;
        PCF       = 32'h0;
    endtask

    task automatic loadSlot(input logic [2:0] idx, input logic valid, input logic [3:0] r,
                            input logic [31:0] val);
        exp_we    = 1'b1;
        exp_idx   = idx;
        exp_valid = valid;
        exp_reg   = r;
        exp_val   = val;
        tick();
        exp_we    = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic endSequence();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 32'h0, END_PC);
    endtask

    task automatic doReset();
        reset = 1'b0;
        #3;
        tick();
        reset = 1'b1;
    endtask

    task automatic waitDone(input string tag, input int maxCycles, output int n);
        n = 0;
        while (!done && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #2;
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_passfail", {30'd0, pass, fail}, 32'd0);
        checkOutput("rst_cycles", cycle_count, 32'd0);
        tick();
        reset = 1'b1;

        // Basic pass: one commit, eight slots checked after the end hold.
        loadSlot(3'd0, 1'b1, 4'd1, 32'd5);
        pulseStart();
        applyStimulus(1'b1, 4'd1, 32'd5, 32'h0);
        endSequence();
        waitDone("t1", 20, waited);
        checkOutput("t1_latency", waited, 32'd8);
        checkOutput("t1_pass", {31'd0, pass}, 32'd1);
        checkOutput("t1_fail", {31'd0, fail}, 32'd0);
        checkOutput("t1_commits", commit_count, 32'd1);
        checkOutput("t1_cycles", cycle_count, 32'd4);

        // Table writes outside IDLE are dropped; table survives a restart.
        loadSlot(3'd0, 1'b1, 4'd1, 32'd99);
        pulseStart();
        checkOutput("t1b_cleared", {29'd0, done, pass, fail}, 32'd0);
        applyStimulus(1'b1, 4'd1, 32'd5, 32'h0);
        endSequence();
        waitDone("t1b", 20, waited);
        checkOutput("t1b_pass", {31'd0, pass}, 32'd1);

        // Mismatch: first failing slot is reported, later failing slot ignored.
        doReset();
        loadSlot(3'd0, 1'b1, 4'd2, 32'd7);
        loadSlot(3'd3, 1'b1, 4'd4, 32'd1);
        pulseStart();
        applyStimulus(1'b1, 4'd2, 32'd6, 32'h0);
        endSequence();
        waitDone("t2", 20, waited);
        checkOutput("t2_latency", waited, 32'd1);
        checkOutput("t2_fail", {31'd0, fail}, 32'd1);
        checkOutput("t2_pass", {31'd0, pass}, 32'd0);
        checkOutput("t2_err_reg", {28'd0, err_reg}, 32'd2);
        checkOutput("t2_err_got", err_got, 32'd6);
        checkOutput("t2_err_exp", err_exp, 32'd7);
        checkOutput("t2_timeout", {31'd0, timeout}, 32'd0);

        // Timeout: PCF never reaches END_PC.
        pulseStart();
        waitDone("t3", 40, waited);
        checkOutput("t3_latency", waited, 32'd16);
        checkOutput("t3_fail", {31'd0, fail}, 32'd1);
        checkOutput("t3_timeout", {31'd0, timeout}, 32'd1);
        checkOutput("t3_cycles", cycle_count, 32'd15);

        // Last write wins, interrupted hold restarts, writeback on the exit cycle is captured.
        doReset();
        loadSlot(3'd0, 1'b1, 4'd3, 32'd9);
        loadSlot(3'd5, 1'b1, 4'd6, 32'd0);
        loadSlot(3'd6, 1'b1, 4'd7, 32'h77);
        pulseStart();
        applyStimulus(1'b1, 4'd3, 32'd1, 32'h0);
        applyStimulus(1'b1, 4'd3, 32'd9, 32'h0);
        applyStimulus(1'b0, 4'd0, 32'h0, END_PC);
        applyStimulus(1'b0, 4'd0, 32'h0, END_PC);
        applyStimulus(1'b0, 4'd0, 32'h0, 32'h0);
        applyStimulus(1'b0, 4'd0, 32'h0, END_PC);
        applyStimulus(1'b0, 4'd0, 32'h0, END_PC);
        applyStimulus(1'b1, 4'd7, 32'h77, END_PC);
        waitDone("t4", 20, waited);
        checkOutput("t4_pass", {30'd0, pass, fail}, 32'd2);
        checkOutput("t4_commits", commit_count, 32'd3);

        // End on the very cycle timeout would fire: end wins.
        pulseStart();
        applyStimulus(1'b1, 4'd3, 32'd9, 32'h0);
        applyStimulus(1'b1, 4'd7, 32'h77, 32'h0);
        for (int i = 0; i < 11; i++) applyStimulus(1'b0, 4'd0, 32'h0, 32'h0);
        endSequence();
        waitDone("t4b", 20, waited);
        checkOutput("t4b_pass", {30'd0, pass, fail}, 32'd2);
        checkOutput("t4b_timeout", {31'd0, timeout}, 32'd0);
        checkOutput("t4b_cycles", cycle_count, 32'd16);

        // Async reset mid-RUN, then rerun with an empty table.
        pulseStart();
        applyStimulus(1'b1, 4'd1, 32'd3, 32'h0);
        applyStimulus(1'b1, 4'd2, 32'd4, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t5_async_commits", commit_count, 32'd0);
        checkOutput("t5_async_cycles", cycle_count, 32'd0);
        checkOutput("t5_async_flags", {29'd0, done, pass, fail}, 32'd0);
        tick();
        reset = 1'b1;
        pulseStart();
        applyStimulus(1'b1, 4'd1, 32'd3, 32'h0);
        endSequence();
        waitDone("t5", 20, waited);
        checkOutput("t5_pass", {30'd0, pass, fail}, 32'd2);

`ifdef WBCHK_TRACE_EN
        // Six commits into a four-deep ring: newest is R5, oldest kept is R2.
        pulseStart();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'(i), 32'(100 + i), 32'h0);
        trace_idx = 2'd0;
        #1;
        checkOutput("t6_idx0_reg", {28'd0, trace_reg}, 32'd5);
        checkOutput("t6_idx0_val", trace_val, 32'd105);
        trace_idx = 2'd1;
        #1;
        checkOutput("t6_idx1_reg", {28'd0, trace_reg}, 32'd4);
        trace_idx = 2'd3;
        #1;
        checkOutput("t6_idx3_reg", {28'd0, trace_reg}, 32'd2);
        checkOutput("t6_idx3_val", trace_val, 32'd102);
        pulseStart();
        trace_idx = 2'd0;
        #1;
        checkOutput("t6_cleared", trace_val, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
